snake_head_ctrl: RTL and testbench

Consumes the game-rate tick from the mod-M tick counter and the debounced direction buttons. Advances the snake head one grid cell per tick and handles wrap-around or wall death. Runs a small game-state machine (IDLE/RUN/PAUSED/DEAD). Its head coordinates and move pulse feed the body/trail buffer and the VGA renderer downstream.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_dir_latch.sv | 50 +++++
 rtl/snake_head_ctrl.sv | 167 ++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake head controller: direction and game-state
// encodings, the reset direction, and a helper that returns the reverse
// of a direction.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam dir_t DIR_RESET = RIGHT;

  // The encoding places each direction two steps from its reverse,
  // so flipping bit 1 gives the opposite direction.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Purpose : priority-encodes the buttons, drops reverse requests, and holds pending_dir.
// Latency : a button level seen on edge k is visible on o_pending_dir after edge k.
// Backpr. : none; i_en gates updates, i_init forces the reset direction.
// Ports   : clk/reset, i_en (update allowed), i_init (reload to RIGHT),
//           i_dir (committed direction), i_btn_* (debounced levels),
//           o_pending_dir (direction to take on the next step).
module snake_dir_latch
  import snake_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_init,
  input  dir_t i_dir,
  input  logic i_btn_up,
  input  logic i_btn_right,
  input  logic i_btn_down,
  input  logic i_btn_left,
  output dir_t o_pending_dir
);

  dir_t r_pending;
  dir_t w_req;
  logic w_req_vld;

  // Fixed priority UP > RIGHT > DOWN > LEFT. The reverse filter is applied
  // to the winner only, so a rejected higher-priority press masks the others.
  always_comb begin
    w_req     = UP;
    w_req_vld = 1'b1;
    if (i_btn_up)         w_req = UP;
    else if (i_btn_right) w_req = RIGHT;
    else if (i_btn_down)  w_req = DOWN;
    else if (i_btn_left)  w_req = LEFT;
    else                  w_req_vld = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= DIR_RESET;
    end else if (i_init) begin
      r_pending <= DIR_RESET;
    end else if (i_en && w_req_vld && (w_req != opposite(i_dir))) begin
      r_pending <= w_req;
    end
  end

  assign o_pending_dir = r_pending;

endmodule

// File: rtl/snake_head_ctrl.sv
// Purpose : steps the snake head one cell per game tick; runs IDLE/RUN/PAUSED/DEAD.
// Latency : tick on edge k -> new head_x/head_y and moved=1 after edge k (1 cycle).
// Backpr. : none; ticks outside RUN are dropped, all outputs registered.
// Ports   : clk/reset, tick, btn_up/right/down/left, start, pause in;
//           head_x, head_y, dir, moved, hit_wall, state out.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter  int GRID_W = 40,
  parameter  int GRID_H = 30,
  parameter  int X_INIT = 20,
  parameter  int Y_INIT = 15,
  parameter  int WRAP   = 1,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          btn_up,
  input  logic          btn_right,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          start,
  input  logic          pause,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir,
  output logic          moved,
  output logic          hit_wall,
  output logic [1:0]    state
);

  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START = XW'(X_INIT);
  localparam logic [YW-1:0] Y_START = YW'(Y_INIT);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  dir_t          r_dir;
  logic          r_moved;
  logic          r_hit;
  state_t        r_state;

  dir_t          w_pending;
  logic          w_start_ok;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_off;

  // Start only counts from IDLE or DEAD; it also reloads pending_dir.
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DEAD));

  snake_dir_latch u_dir_latch (
    .clk           (clk),
    .reset         (reset),
    .i_en          (r_state == RUN),
    .i_init        (w_start_ok),
    .i_dir         (r_dir),
    .i_btn_up      (btn_up),
    .i_btn_right   (btn_right),
    .i_btn_down    (btn_down),
    .i_btn_left    (btn_left),
    .o_pending_dir (w_pending)
  );

  // Candidate next cell. Edges are detected against the grid bounds rather
  // than by overflow, because the grid need not be a power of two. w_off
  // flags a step that leaves the grid; w_nx/w_ny already hold the wrapped cell.
  always_comb begin
    w_nx  = r_x;
    w_ny  = r_y;
    w_off = 1'b0;
    case (w_pending)
      UP: begin
        if (r_y == '0) begin
          w_off = 1'b1;
          w_ny  = Y_MAX;
        end else begin
          w_ny  = r_y - Y_ONE;
        end
      end
      DOWN: begin
        if (r_y == Y_MAX) begin
          w_off = 1'b1;
          w_ny  = '0;
        end else begin
          w_ny  = r_y + Y_ONE;
        end
      end
      LEFT: begin
        if (r_x == '0) begin
          w_off = 1'b1;
          w_nx  = X_MAX;
        end else begin
          w_nx  = r_x - X_ONE;
        end
      end
      RIGHT: begin
        if (r_x == X_MAX) begin
          w_off = 1'b1;
          w_nx  = '0;
        end else begin
          w_nx  = r_x + X_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= X_START;
      r_y     <= Y_START;
      r_dir   <= DIR_RESET;
      r_moved <= 1'b0;
      r_hit   <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_moved <= 1'b0;
      case (r_state)
        IDLE, DEAD: begin
          // No step on the start cycle even if tick coincides.
          if (start) begin
            r_x     <= X_START;
            r_y     <= Y_START;
            r_dir   <= DIR_RESET;
            r_hit   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            r_dir <= w_pending;
            if (w_off && (WRAP == 0)) begin
              // Head stays on its last in-grid cell; no move pulse.
              r_hit   <= 1'b1;
              r_state <= DEAD;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_moved <= 1'b1;
              if (pause) r_state <= PAUSED;
            end
          end else if (pause) begin
            r_state <= PAUSED;
          end
        end
        PAUSED: begin
          if (pause) r_state <= RUN;
        end
        default: ;
      endcase
    end
  end

  assign head_x   = r_x;
  assign head_y   = r_y;
  assign dir      = r_dir;
  assign moved    = r_moved;
  assign hit_wall = r_hit;
  assign state    = r_state;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: one wrapping and one non-wrapping instance share
// the stimulus; each step pushes its hand-derived expectation to a scoreboard
// and pops it after the clock edge to compare against the selected instance.
module tb_snake_head_ctrl;

  localparam logic [1:0] D_U = 2'd0, D_R = 2'd1, D_D = 2'd2, D_L = 2'd3;
  localparam logic [1:0] S_I = 2'd0, S_R = 2'd1, S_P = 2'd2, S_D = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic tick, btn_up, btn_right, btn_down, btn_left, start, pause;

  logic [5:0] hx, hx_nw;
  logic [4:0] hy, hy_nw;
  logic [1:0] dir, dir_nw, st, st_nw;
  logic       mv, mv_nw, hit, hit_nw;

  snake_head_ctrl #(.WRAP(1)) u_dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .start(start), .pause(pause),
    .head_x(hx), .head_y(hy), .dir(dir), .moved(mv), .hit_wall(hit), .state(st)
  );

  snake_head_ctrl #(.WRAP(0)) u_dut_nw (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
    .start(start), .pause(pause),
    .head_x(hx_nw), .head_y(hy_nw), .dir(dir_nw), .moved(mv_nw), .hit_wall(hit_nw), .state(st_nw)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
    logic [1:0] d;
    logic       mv;
    logic       hit;
    logic [1:0] st;
  } exp_t;

  typedef struct packed {
    logic tick, up, rt, dn, lt, start, pause;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mke(input int x, input int y, input logic [1:0] d,
                               input logic m, input logic h, input logic [1:0] s);
    exp_t e;
    e.x   = 6'(x);
    e.y   = 5'(y);
    e.d   = d;
    e.mv  = m;
    e.hit = h;
    e.st  = s;
    return e;
  endfunction

  // Inputs: tick up right down left start pause; then expected state after the edge.
  function automatic vec_t mk(input logic t, input logic u, input logic r, input logic dn,
                              input logic l, input logic s, input logic p,
                              input int x, input int y, input logic [1:0] d,
                              input logic m, input logic h, input logic [1:0] sst);
    vec_t v;
    v.tick  = t;
    v.up    = u;
    v.rt    = r;
    v.dn    = dn;
    v.lt    = l;
    v.start = s;
    v.pause = p;
    v.e     = mke(x, y, d, m, h, sst);
    return v;
  endfunction

  task automatic cmp(input exp_t e, input bit nw, input string tag);
    exp_t a;
    if (nw) a = '{x: hx_nw, y: hy_nw, d: dir_nw, mv: mv_nw, hit: hit_nw, st: st_nw};
    else    a = '{x: hx, y: hy, d: dir, mv: mv, hit: hit, st: st};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d dir=%0d moved=%0b hit=%0b state=%0d, expected x=%0d y=%0d dir=%0d moved=%0b hit=%0b state=%0d",
               tag, a.x, a.y, a.d, a.mv, a.hit, a.st, e.x, e.y, e.d, e.mv, e.hit, e.st);
    end
  endtask

  task automatic step(input vec_t v, input bit nw, input string tag);
    tick      = v.tick;
    btn_up    = v.up;
    btn_right = v.rt;
    btn_down  = v.dn;
    btn_left  = v.lt;
    start     = v.start;
    pause     = v.pause;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    tick = 1'b0; btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    start = 1'b0; pause = 1'b0;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      cmp(sb.pop_front(), nw, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick = 1'b0; btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    start = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp(mke(20, 15, D_R, 0, 0, S_I), 1'b0, "reset");
    cmp(mke(20, 15, D_R, 0, 0, S_I), 1'b1, "reset_nw");
    reset = 1'b0;

    //             t u r d l s p    x   y  dir  mv hit st
    tbl.push_back(mk(1,0,0,0,0,0,0, 20, 15, D_R, 0, 0, S_I)); // tick ignored in IDLE
    tbl.push_back(mk(0,0,0,0,0,0,1, 20, 15, D_R, 0, 0, S_I)); // pause ignored in IDLE
    tbl.push_back(mk(1,0,0,0,0,1,0, 20, 15, D_R, 0, 0, S_R)); // start+tick: no move
    tbl.push_back(mk(1,0,0,0,0,0,0, 21, 15, D_R, 1, 0, S_R));
    tbl.push_back(mk(0,0,0,0,0,0,0, 21, 15, D_R, 0, 0, S_R)); // moved is one cycle
    tbl.push_back(mk(1,0,0,0,0,0,0, 22, 15, D_R, 1, 0, S_R));
    tbl.push_back(mk(1,0,0,0,0,0,0, 23, 15, D_R, 1, 0, S_R));
    tbl.push_back(mk(0,0,0,0,1,0,0, 23, 15, D_R, 0, 0, S_R)); // reverse request
    tbl.push_back(mk(1,0,0,0,0,0,0, 24, 15, D_R, 1, 0, S_R)); // still RIGHT
    tbl.push_back(mk(0,1,0,0,0,0,0, 24, 15, D_R, 0, 0, S_R));
    tbl.push_back(mk(1,0,0,0,0,0,0, 24, 14, D_U, 1, 0, S_R)); // turn up
    tbl.push_back(mk(0,0,0,0,0,1,0, 24, 14, D_U, 0, 0, S_R)); // start ignored in RUN
    tbl.push_back(mk(0,0,1,0,0,0,0, 24, 14, D_U, 0, 0, S_R)); // pending RIGHT
    tbl.push_back(mk(0,0,0,0,1,0,0, 24, 14, D_U, 0, 0, S_R)); // last press LEFT wins
    tbl.push_back(mk(1,0,0,0,0,0,0, 23, 14, D_L, 1, 0, S_R));
    tbl.push_back(mk(0,0,1,1,0,0,0, 23, 14, D_L, 0, 0, S_R)); // RIGHT wins priority, is reverse
    tbl.push_back(mk(1,0,0,0,0,0,0, 22, 14, D_L, 1, 0, S_R));
    tbl.push_back(mk(0,1,0,1,0,0,0, 22, 14, D_L, 0, 0, S_R)); // UP beats DOWN
    tbl.push_back(mk(1,0,0,0,0,0,0, 22, 13, D_U, 1, 0, S_R));
    tbl.push_back(mk(1,0,0,0,0,0,1, 22, 12, D_U, 1, 0, S_P)); // move then pause
    tbl.push_back(mk(1,0,0,0,1,0,0, 22, 12, D_U, 0, 0, S_P)); // frozen
    tbl.push_back(mk(0,0,0,0,0,1,0, 22, 12, D_U, 0, 0, S_P)); // start ignored
    tbl.push_back(mk(0,0,0,0,0,0,1, 22, 12, D_U, 0, 0, S_R)); // resume
    tbl.push_back(mk(1,0,0,0,0,0,0, 22, 11, D_U, 1, 0, S_R)); // LEFT was not latched
    tbl.push_back(mk(0,0,0,0,0,0,1, 22, 11, D_U, 0, 0, S_P));
    tbl.push_back(mk(0,0,0,0,0,0,1, 22, 11, D_U, 0, 0, S_R));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b0, $sformatf("tbl[%0d]", i));

    // Wrapping instance: walk to every edge and cross it.
    for (int k = 1; k <= 11; k++)
      step(mk(1,0,0,0,0,0,0, 22, 11 - k, D_U, 1, 0, S_R), 1'b0, $sformatf("walk_up[%0d]", k));
    step(mk(1,0,0,0,0,0,0, 22, 29, D_U, 1, 0, S_R), 1'b0, "wrap_top");
    step(mk(0,0,1,0,0,0,0, 22, 29, D_U, 0, 0, S_R), 1'b0, "press_right");
    step(mk(1,0,0,0,0,0,0, 23, 29, D_R, 1, 0, S_R), 1'b0, "turn_right");
    for (int k = 1; k <= 16; k++)
      step(mk(1,0,0,0,0,0,0, 23 + k, 29, D_R, 1, 0, S_R), 1'b0, $sformatf("walk_right[%0d]", k));
    step(mk(1,0,0,0,0,0,0, 0, 29, D_R, 1, 0, S_R), 1'b0, "wrap_right");
    step(mk(0,0,0,1,0,0,0, 0, 29, D_R, 0, 0, S_R), 1'b0, "press_down");
    step(mk(1,0,0,0,0,0,0, 0, 0, D_D, 1, 0, S_R), 1'b0, "wrap_bottom");
    step(mk(0,0,0,0,1,0,0, 0, 0, D_D, 0, 0, S_R), 1'b0, "press_left");
    step(mk(1,0,0,0,0,0,0, 39, 0, D_L, 1, 0, S_R), 1'b0, "wrap_left");

    // Asynchronous reset between clock edges.
    #3 reset = 1'b1;
    #1;
    cmp(mke(20, 15, D_R, 0, 0, S_I), 1'b0, "async_reset");
    @(posedge clk);
    #1;
    cmp(mke(20, 15, D_R, 0, 0, S_I), 1'b0, "reset_held");
    reset = 1'b0;

    // Non-wrapping instance: reach (39,10) heading RIGHT, then cross the wall.
    step(mk(0,0,0,0,0,1,0, 20, 15, D_R, 0, 0, S_R), 1'b1, "nw_start");
    step(mk(0,1,0,0,0,0,0, 20, 15, D_R, 0, 0, S_R), 1'b1, "nw_press_up");
    for (int k = 1; k <= 5; k++)
      step(mk(1,0,0,0,0,0,0, 20, 15 - k, D_U, 1, 0, S_R), 1'b1, $sformatf("nw_up[%0d]", k));
    step(mk(0,0,1,0,0,0,0, 20, 10, D_U, 0, 0, S_R), 1'b1, "nw_press_right");
    for (int k = 1; k <= 19; k++)
      step(mk(1,0,0,0,0,0,0, 20 + k, 10, D_R, 1, 0, S_R), 1'b1, $sformatf("nw_right[%0d]", k));
    step(mk(1,0,0,0,0,0,0, 39, 10, D_R, 0, 1, S_D), 1'b1, "nw_wall");
    step(mk(1,1,0,0,0,0,1, 39, 10, D_R, 0, 1, S_D), 1'b1, "nw_dead_ignores");
    step(mk(0,0,0,0,0,1,0, 20, 15, D_R, 0, 0, S_R), 1'b1, "nw_restart");
    step(mk(1,0,0,0,0,0,0, 21, 15, D_R, 1, 0, S_R), 1'b1, "nw_restart_move");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
